// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the execute-stage multiply/divide engine.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITERS = 32;

    // Opcodes decoded by execute control to raise startMult / startDiv
    localparam logic [4:0] OPC_MUL = 5'b00110;
    localparam logic [4:0] OPC_DIV = 5'b00111;

endpackage

// File: rtl/mult_div_unit_divider_step.sv
// One combinational iteration of a non-restoring divider on unsigned magnitudes.
// The partial remainder is kept signed and one bit wider than the divisor; the
// working arithmetic is two bits wider so that 2*rem + bit never overflows,
// even for a divisor of 0x80000000.
module nonrestoring_divider_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_div;
    logic [WIDTH+1:0] w_new;

    // Shift the next dividend bit in; subtract when the remainder is
    // non-negative, add back otherwise. The quotient bit is the new sign inverted.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_div   = {2'b00, i_divisor};
        w_new   = i_rem[WIDTH] ? (w_shift + w_div) : (w_shift - w_div);
        o_rem   = w_new[WIDTH:0];
        o_quo   = {i_quo[WIDTH-2:0], ~w_new[WIDTH+1]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) engine.
// Accepts a start pulse, iterates ITERS cycles, then pulses multDivDone once.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             startMult,
    input  logic             startDiv,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             multDivDone,
    output logic             busy
);
    import mult_div_unit_pkg::*;

    md_state_t        r_state;
    md_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_neg;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_qmul_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-2+2:0] w_ovf_bits;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_res;
    logic             w_exc;

    assign w_start  = startMult | startDiv;
    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && w_start;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(ITERS - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state: DONE lasts one cycle and may hand straight over to RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = w_start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Booth step: the add/sub is done one bit wider so that subtracting a
    // multiplicand of -2^(WIDTH-1) keeps the correct sign through the shift.
    always_comb begin
        w_booth_sum = {r_acc[WIDTH-1], r_acc};
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = {r_acc[WIDTH-1], r_acc} + {r_m[WIDTH-1], r_m};
            2'b10:   w_booth_sum = {r_acc[WIDTH-1], r_acc} - {r_m[WIDTH-1], r_m};
            default: w_booth_sum = {r_acc[WIDTH-1], r_acc};
        endcase
        w_acc_nxt  = w_booth_sum[WIDTH:1];
        w_qmul_nxt = {w_booth_sum[0], r_q[WIDTH-1:1]};
        w_prod     = {w_acc_nxt, w_qmul_nxt};
        w_ovf_bits = w_prod[2*WIDTH-1:WIDTH-1];
    end

    nonrestoring_divider_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_q),
        .i_divisor (r_m),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // Final result from the last iteration's outputs, registered at the last edge
    always_comb begin
        w_res = '0;
        w_exc = 1'b0;
        if (r_op == OP_MULT) begin
            w_res = w_prod[WIDTH-1:0];
            w_exc = ~((&w_ovf_bits) | ~(|w_ovf_bits));
        end else if (r_m == '0) begin
            w_res = '0;
            w_exc = 1'b1;
        end else begin
            w_res = r_neg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
            w_exc = 1'b0;
        end
    end

    // Operand latch on accept, one iteration per RUN cycle, result capture at the end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= OP_MULT;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_qm1 <= 1'b0;
            r_rem <= '0;
            if (startMult) begin
                r_op  <= OP_MULT;
                r_neg <= 1'b0;
                r_q   <= operandA;
                r_m   <= operandB;
            end else begin
                // Divide works on magnitudes; 0x80000000 negates to itself,
                // which is the correct unsigned magnitude.
                r_op  <= OP_DIV;
                r_neg <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                r_q   <= operandA[WIDTH-1] ? (~operandA + 1'b1) : operandA;
                r_m   <= operandB[WIDTH-1] ? (~operandB + 1'b1) : operandB;
            end
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == OP_MULT) begin
                r_acc <= w_acc_nxt;
                r_q   <= w_qmul_nxt;
                r_qm1 <= r_q[0];
            end else begin
                r_rem <= w_rem_nxt;
                r_q   <= w_quo_nxt;
            end
            if (w_last) begin
                r_result <= w_res;
                r_exc    <= w_exc;
            end
        end
    end

    assign result      = r_result;
    assign exception   = r_exc;
    assign multDivDone = (r_state == DONE);
    assign busy        = (r_state == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written corner sequences.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        startMult = 1'b0;
    logic        startDiv = 1'b0;
    logic [31:0] result;
    logic        exception;
    logic        multDivDone;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    mult_div_unit #(.WIDTH(32), .ITERS(32), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .operandA    (operandA),
        .operandB    (operandB),
        .startMult   (startMult),
        .startDiv    (startDiv),
        .result      (result),
        .exception   (exception),
        .multDivDone (multDivDone),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic        sd;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive a one-cycle start from a negedge; returns 1ns after the accepting edge
    // with operands scrambled so the latched copies are what matter.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm, input logic sd);
        operandA  = a;
        operandB  = b;
        startMult = sm;
        startDiv  = sd;
        @(posedge clock);
        #1;
        startMult = 1'b0;
        startDiv  = 1'b0;
        operandA  = $urandom;
        operandB  = $urandom;
    endtask

    // Counts edges until done is seen at a negedge; busy must stay high before it.
    task automatic wait_done(input string nm, input int exp_cyc);
        int n;
        int busy_bad;
        n = 0;
        busy_bad = 0;
        do begin
            @(posedge clock);
            @(negedge clock);
            n++;
            if (!multDivDone && !busy) busy_bad++;
        end while (!multDivDone && n < 100);
        chk({nm, " latency"}, 32'(n), 32'(exp_cyc));
        chk({nm, " busy gaps"}, 32'(busy_bad), 32'd0);
        chk({nm, " busy in done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic count_done(input string nm, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (multDivDone) pulses++;
        end
        chk({nm, " stray done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        vt[0]  = '{32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0};
        vt[1]  = '{32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vt[2]  = '{32'h40000000, 32'd2,        1'b1, 1'b0, 32'h80000000, 1'b1};
        vt[3]  = '{32'hFFFFFFEF, 32'd5,        1'b0, 1'b1, 32'hFFFFFFFD, 1'b0};
        vt[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0};
        vt[5]  = '{32'd123,      32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1};
        vt[6]  = '{32'd6,        32'd7,        1'b1, 1'b1, 32'd42,       1'b0};
        vt[7]  = '{32'hFFFFFFFA, 32'hFFFFFFF9, 1'b1, 1'b0, 32'd42,       1'b0};
        vt[8]  = '{32'd100,      32'hFFFFFFF9, 1'b0, 1'b1, 32'hFFFFFFF2, 1'b0};
        vt[9]  = '{32'd1,        32'h80000000, 1'b1, 1'b0, 32'h80000000, 1'b0};
        vt[10] = '{32'd3,        32'h80000000, 1'b1, 1'b0, 32'h80000000, 1'b1};
        vt[11] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b0};
        vt[12] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000001, 1'b0};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'd0, exception, multDivDone, busy, 1'b0}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].sm, vt[i].sd);
            chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
            wait_done($sformatf("v%0d", i), 32);
            chk($sformatf("v%0d result", i), result, vt[i].res);
            chk($sformatf("v%0d exc", i), {31'd0, exception}, {31'd0, vt[i].exc});
            @(negedge clock);
            chk($sformatf("v%0d done width", i), {31'd0, multDivDone}, 32'd0);
            chk($sformatf("v%0d hold", i), result, vt[i].res);
        end

        // Back-to-back: a start in the DONE cycle goes straight to RUN
        issue(32'd123, 32'd0, 1'b0, 1'b1);
        wait_done("b2b div0", 32);
        chk("b2b div0 result", result, 32'd0);
        chk("b2b div0 exc", {31'd0, exception}, 32'd1);
        issue(32'd6, 32'd7, 1'b1, 1'b0);
        chk("b2b no gap busy", {31'd0, busy}, 32'd1);
        chk("b2b no gap done", {31'd0, multDivDone}, 32'd0);
        wait_done("b2b mul", 32);
        chk("b2b mul result", result, 32'd42);
        chk("b2b mul exc", {31'd0, exception}, 32'd0);

        // Start during RUN is ignored, operands changing mid-run have no effect
        @(negedge clock);
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (9) @(posedge clock);
        @(negedge clock);
        operandA  = 32'd5;
        operandB  = 32'd5;
        startMult = 1'b1;
        @(posedge clock);
        #1;
        startMult = 1'b0;
        operandA  = 32'hDEADBEEF;
        wait_done("run start", 22);
        chk("run start result", result, 32'd14);
        chk("run start exc", {31'd0, exception}, 32'd0);
        count_done("run start", 40);

        // Asynchronous reset mid-multiply clears outputs at once, no done follows
        issue(32'd7, 32'hFFFFFFFD, 1'b1, 1'b0);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst result", result, 32'd0);
        chk("async rst flags", {29'd0, exception, multDivDone, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        count_done("after rst", 40);
        chk("after rst busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide engine in the execute stage; the responder for the `startMult`/`startDiv` requests raised by execute control.
- Latches operands on a start pulse and iterates for a fixed 32 cycles.
- Returns a 32-bit result plus exception flag, with a one-cycle `multDivDone` pulse that releases the pipeline stall.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified).
- ITERS, 32, iteration count; equals WIDTH.
- CNT_W, 6, counter width; must hold 0..ITERS.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- operandA  input  32  multiplicand / dividend (two's complement).
- operandB  input  32  multiplier / divisor (two's complement).
- startMult  input  1  one-cycle request: A*B.
- startDiv  input  1  one-cycle request: A/B.
- result  output  32  low 32 bits of product, or quotient.
- exception  output  1  multiply overflow or divide-by-zero.
- multDivDone  output  1  one-cycle pulse, result/exception valid.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, any state, including mid-operation):
  - state=IDLE, counter=0, all datapath registers=0.
  - result=0, exception=0, multDivDone=0, busy=0.
  - The in-flight operation is discarded; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - startMult|startDiv sampled high at edge E0 → RUN.
  - At E0: latch operandA/B, latch op=MULT if startMult else DIV, counter=0, busy=1.
- Start priority: both starts high → MULT; startDiv ignored.
- RUN:
  - One iteration per edge, counter+1.
  - The edge taking counter to ITERS (E32) → DONE.
  - At E32: result and exception registered, multDivDone=1, busy=0.
- DONE: lasts exactly one cycle.
  - Next edge → IDLE and multDivDone=0.
  - If a start is sampled at that edge → RUN directly (back-to-back accepted, same latching as IDLE).
- Start in RUN: ignored. No queuing, and operands are not re-latched.
- Latency: done visible in the cycle after edge E32, i.e. 32 cycles after the accepting edge.
- result/exception hold their values until the next DONE or reset.
- Multiply:
  - Radix-2 Booth, 65-bit {acc, Q, q-1} register, arithmetic right shift each iteration.
  - result = product[31:0].
  - exception=1 iff product[63:31] is not all-0 or all-1 (signed overflow).
- Divide:
  - Non-restoring on magnitudes; quotient sign = signA XOR signB, truncation toward zero; remainder discarded.
  - B=0: full 32 cycles still run; result=0, exception=1.
  - 0x80000000 / -1: result=0x80000000, exception=0.
- Operand inputs may change freely after the accepting edge without affecting the result.

Decomposition:
- Shared package holds:
  - State encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - OP_MULT=1'b0, OP_DIV=1'b1.
  - ITERS=32, plus the opcode constants 5'b00110 (mul) and 5'b00111 (div) shared with execute control.
- One sub-module: nonrestoring_divider_step, a combinational single iteration (partial remainder, quotient bit).
- Booth step stays inline in the top FSM/datapath.

Test Plan:
- Basic multiply: reset, A=7, B=-3, startMult 1 cycle → multDivDone high exactly 32 cycles later for 1 cycle, result=0xFFFFFFEB, exception=0, busy high for cycles 1–32.
- Multiply overflow: A=0x00010000, B=0x00010000, startMult → result=0x00000000, exception=1. Then A=0x40000000, B=2 → result=0x80000000, exception=1.
- Signed divide: A=-17, B=5, startDiv → result=-3 (0xFFFFFFFD), exception=0. A=0x80000000, B=-1 → result=0x80000000, exception=0.
- Divide by zero, then back-to-back start: A=123, B=0, startDiv → done after 32 cycles, result=0, exception=1. In the DONE cycle assert startMult A=6, B=7 → second done 32 cycles later, result=42; no idle gap.
- Start during RUN: startMult asserted at cycle 10 of a running divide with different operands → ignored; single done with the divide result; operandA/B changed mid-run have no effect.
- Mid-operation reset: reset high async at cycle 15 of a multiply → outputs 0 immediately (before the next edge); no done pulse afterwards. Both starts high together → multiply performed.
